// File: rtl/id_pkg.sv
// Decode-stage constants for the 5-stage MIPS pipeline:
// opcodes, funct codes, ALU operations and the control bundle.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2a;

    typedef enum logic [5:0] {
        ALU_NOP = 6'd0,
        ALU_ADD = 6'd1,
        ALU_SUB = 6'd2,
        ALU_AND = 6'd3,
        ALU_OR  = 6'd4,
        ALU_SLT = 6'd5,
        ALU_NOR = 6'd6,
        ALU_XOR = 6'd7,
        ALU_SLL = 6'd8,
        ALU_SRL = 6'd9,
        ALU_SRA = 6'd10,
        ALU_SNE = 6'd11
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    branch;
        logic    mem_read;
        logic    mem_write;
        logic    reg_dst;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    function automatic alu_op_e funct_alu(input logic [5:0] f);
        alu_op_e op;
        case (f)
            F_SLL:  op = ALU_SLL;
            F_SRL:  op = ALU_SRL;
            F_SRA:  op = ALU_SRA;
            F_ADD:  op = ALU_ADD;
            F_ADDU: op = ALU_ADD;
            F_SUB:  op = ALU_SUB;
            F_AND:  op = ALU_AND;
            F_OR:   op = ALU_OR;
            F_XOR:  op = ALU_XOR;
            F_NOR:  op = ALU_NOR;
            F_SLT:  op = ALU_SLT;
            default: op = ALU_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stage_id_pipe_if.sv
// Decode-stage bundle: IF/ID inputs, write-back port, flush,
// stall back-pressure and the registered ID/EX outputs.
interface stage_id_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 6
);
    logic [31:0]           Instruction;
    logic [DATA_W-1:0]     PCAddResult_in;
    logic                  IFID_Valid;
    logic                  WB_RegWrite;
    logic [REG_ADDR_W-1:0] WB_WriteRegister;
    logic [DATA_W-1:0]     WB_WriteData;
    logic                  Flush;
    logic                  Stall;
    logic                  EX_Valid;
    logic                  EX_RegWrite;
    logic                  EX_MemtoReg;
    logic                  EX_Branch;
    logic                  EX_MemRead;
    logic                  EX_MemWrite;
    logic                  EX_RegDst;
    logic                  EX_ALUSrc;
    logic [ALUOP_W-1:0]    EX_ALUOp;
    logic [DATA_W-1:0]     EX_PCAddResult;
    logic [DATA_W-1:0]     EX_ReadData1;
    logic [DATA_W-1:0]     EX_ReadData2;
    logic [DATA_W-1:0]     EX_SignExtResult;
    logic [REG_ADDR_W-1:0] EX_rs;
    logic [REG_ADDR_W-1:0] EX_rt;
    logic [REG_ADDR_W-1:0] EX_rd;

    modport master (
        output Instruction, PCAddResult_in, IFID_Valid,
        output WB_RegWrite, WB_WriteRegister, WB_WriteData,
        output Flush,
        input  Stall, EX_Valid,
        input  EX_RegWrite, EX_MemtoReg, EX_Branch,
        input  EX_MemRead, EX_MemWrite, EX_RegDst, EX_ALUSrc,
        input  EX_ALUOp, EX_PCAddResult,
        input  EX_ReadData1, EX_ReadData2, EX_SignExtResult,
        input  EX_rs, EX_rt, EX_rd
    );

    modport slave (
        input  Instruction, PCAddResult_in, IFID_Valid,
        input  WB_RegWrite, WB_WriteRegister, WB_WriteData,
        input  Flush,
        output Stall, EX_Valid,
        output EX_RegWrite, EX_MemtoReg, EX_Branch,
        output EX_MemRead, EX_MemWrite, EX_RegDst, EX_ALUSrc,
        output EX_ALUOp, EX_PCAddResult,
        output EX_ReadData1, EX_ReadData2, EX_SignExtResult,
        output EX_rs, EX_rt, EX_rd
    );

endinterface

// File: rtl/id_ctrl_decode.sv
// Combinational main control: opcode/funct to control bundle,
// plus whether the instruction reads rt as a source.
module id_ctrl_decode
    import id_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic       uses_rt
);

    alu_op_e r_op;

    assign r_op = funct_alu(funct);

    always_comb begin
        ctrl    = '0;
        uses_rt = 1'b0;
        unique case (1'b1)
            opcode == OP_RTYPE: begin
                uses_rt = 1'b1;
                if (r_op != ALU_NOP) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                    ctrl.alu_op    = r_op;
                end
            end
            opcode == OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALU_ADD;
            end
            opcode == OP_SW: begin
                uses_rt        = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            opcode == OP_BEQ: begin
                uses_rt     = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            opcode == OP_BNE: begin
                uses_rt     = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SNE;
            end
            opcode == OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            opcode == OP_ANDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_AND;
            end
            opcode == OP_ORI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_OR;
            end
            opcode == OP_SLTI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_SLT;
            end
            // jump target is resolved in fetch; nothing flows to EX
            opcode == OP_J: begin
                ctrl = '0;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/stage_id_pipe.sv
// MIPS decode stage: register file with WB bypass, sign extension,
// control decode, load-use stall and the ID/EX pipeline register.
module stage_id_pipe
    import id_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 6
) (
    input logic            Clk,
    input logic            Reset,
    stage_id_pipe_if.slave bus
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     rdata1;
    logic [DATA_W-1:0]     rdata2;
    logic [DATA_W-1:0]     sext;
    ctrl_t                 ctrl;
    logic                  uses_rt;
    logic                  wb_hit;
    logic                  stall;
    logic                  kill;

    logic [DATA_W-1:0]     regs [NUM_REGS];

    logic                  ex_valid;
    ctrl_t                 ex_ctrl;
    logic [DATA_W-1:0]     ex_pc;
    logic [DATA_W-1:0]     ex_rd1;
    logic [DATA_W-1:0]     ex_rd2;
    logic [DATA_W-1:0]     ex_sext;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic [REG_ADDR_W-1:0] ex_rd;

    assign opcode = bus.Instruction[31:26];
    assign funct  = bus.Instruction[5:0];
    assign rs     = REG_ADDR_W'(bus.Instruction[25:21]);
    assign rt     = REG_ADDR_W'(bus.Instruction[20:16]);
    assign rd     = REG_ADDR_W'(bus.Instruction[15:11]);
    assign sext   = DATA_W'($signed(bus.Instruction[15:0]));

    id_ctrl_decode u_dec (
        .opcode  (opcode),
        .funct   (funct),
        .ctrl    (ctrl),
        .uses_rt (uses_rt)
    );

    assign wb_hit = bus.WB_RegWrite && (bus.WB_WriteRegister != '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_hit) begin
            regs[bus.WB_WriteRegister] <= bus.WB_WriteData;
        end
    end

    // same-cycle WB forwarding avoids a write-then-read hazard
    always_comb begin
        rdata1 = regs[rs];
        if (rs == '0) begin
            rdata1 = '0;
        end else if (wb_hit && (bus.WB_WriteRegister == rs)) begin
            rdata1 = bus.WB_WriteData;
        end
    end

    always_comb begin
        rdata2 = regs[rt];
        if (rt == '0) begin
            rdata2 = '0;
        end else if (wb_hit && (bus.WB_WriteRegister == rt)) begin
            rdata2 = bus.WB_WriteData;
        end
    end

    assign stall = bus.IFID_Valid & ex_valid & ex_ctrl.mem_read
                 & (ex_rt != '0)
                 & ((ex_rt == rs) | (uses_rt & (ex_rt == rt)));

    // flush, stall bubble and empty slot all leave EX with no control
    assign kill = bus.Flush | stall | ~bus.IFID_Valid;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_pc    <= '0;
            ex_rd1   <= '0;
            ex_rd2   <= '0;
            ex_sext  <= '0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
        end else begin
            ex_valid <= ~kill;
            ex_ctrl  <= kill ? '0 : ctrl;
            ex_pc    <= bus.PCAddResult_in;
            ex_rd1   <= rdata1;
            ex_rd2   <= rdata2;
            ex_sext  <= sext;
            ex_rs    <= rs;
            ex_rt    <= rt;
            ex_rd    <= rd;
        end
    end

    assign bus.Stall            = stall;
    assign bus.EX_Valid         = ex_valid;
    assign bus.EX_RegWrite      = ex_ctrl.reg_write;
    assign bus.EX_MemtoReg      = ex_ctrl.mem_to_reg;
    assign bus.EX_Branch        = ex_ctrl.branch;
    assign bus.EX_MemRead       = ex_ctrl.mem_read;
    assign bus.EX_MemWrite      = ex_ctrl.mem_write;
    assign bus.EX_RegDst        = ex_ctrl.reg_dst;
    assign bus.EX_ALUSrc        = ex_ctrl.alu_src;
    assign bus.EX_ALUOp         = ALUOP_W'(ex_ctrl.alu_op);
    assign bus.EX_PCAddResult   = ex_pc;
    assign bus.EX_ReadData1     = ex_rd1;
    assign bus.EX_ReadData2     = ex_rd2;
    assign bus.EX_SignExtResult = ex_sext;
    assign bus.EX_rs            = ex_rs;
    assign bus.EX_rt            = ex_rt;
    assign bus.EX_rd            = ex_rd;

endmodule

// File: tb/tb_stage_id_pipe.sv
// Scoreboard bench for stage_id_pipe: 32-bit instance for the
// pipeline behaviour, 64-bit instance for wide sign extension.
module tb_stage_id_pipe;
    import id_pkg::*;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    stage_id_pipe_if #(.DATA_W(32), .REG_ADDR_W(5), .ALUOP_W(6)) bus ();
    stage_id_pipe_if #(.DATA_W(64), .REG_ADDR_W(5), .ALUOP_W(6)) bus64 ();

    stage_id_pipe #(.DATA_W(32), .REG_ADDR_W(5), .ALUOP_W(6)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    stage_id_pipe #(.DATA_W(64), .REG_ADDR_W(5), .ALUOP_W(6)) dut64 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus64)
    );

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        mr;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] se;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb [$];
    logic [63:0] sb64 [$];

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] f);
        return {6'h00, s, t, d, 5'h00, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {o, s, t, imm};
    endfunction

    function automatic logic [31:0] sx(input logic [31:0] i);
        return {{16{i[15]}}, i[15:0]};
    endfunction

    function automatic exp_t obs();
        return {bus.EX_Valid, bus.EX_RegWrite, bus.EX_MemRead, bus.EX_ALUOp,
                bus.EX_rs, bus.EX_ReadData1, bus.EX_ReadData2,
                bus.EX_SignExtResult, bus.EX_PCAddResult};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic vld, input logic fl);
        bus.Instruction    = ins;
        bus.PCAddResult_in = pc;
        bus.IFID_Valid     = vld;
        bus.Flush          = fl;
    endtask

    task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.WB_RegWrite      = we;
        bus.WB_WriteRegister = a;
        bus.WB_WriteData     = d;
    endtask

    task automatic test_reset();
        exp_t a;
        Reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        wb(1'b0, 5'd0, 32'h0);
        bus64.Instruction      = '0;
        bus64.PCAddResult_in   = '0;
        bus64.IFID_Valid       = 1'b0;
        bus64.WB_RegWrite      = 1'b0;
        bus64.WB_WriteRegister = '0;
        bus64.WB_WriteData     = '0;
        bus64.Flush            = 1'b0;
        @(negedge Clk);
        a = obs();
        checks++;
        if (a !== '0) begin
            errors++;
            $display("FAIL reset_ex got %h want 0", a);
        end
        checks++;
        if ({bus.Stall, bus.EX_rt, bus.EX_rd, bus.EX_MemWrite} !== '0) begin
            errors++;
            $display("FAIL reset_misc got %b want 0",
                     {bus.Stall, bus.EX_rt, bus.EX_rd, bus.EX_MemWrite});
        end
        checks++;
        if ({bus64.EX_Valid, bus64.EX_SignExtResult} !== '0) begin
            errors++;
            $display("FAIL reset_64 got %h want 0", bus64.EX_SignExtResult);
        end
        Reset = 1'b0;
    endtask

    task automatic test_bypass();
        exp_t e, a;
        logic [31:0] ins;
        @(negedge Clk);
        ins = rtype(5'd8, 5'd0, 5'd9, F_ADD);
        wb(1'b1, 5'd8, 32'h1234_5678);
        drive(ins, 32'h104, 1'b1, 1'b0);
        sb.push_back('{v:1'b1, rw:1'b1, mr:1'b0, op:ALU_ADD, rs:5'd8,
                       d1:32'h1234_5678, d2:32'h0, se:sx(ins), pc:32'h104});
        @(posedge Clk); #1;
        e = sb.pop_front(); a = obs();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL bypass got %h want %h", a, e);
        end
        checks++;
        if ({bus.EX_rd, bus.EX_RegDst} !== {5'd9, 1'b1}) begin
            errors++;
            $display("FAIL bypass_rd got %h want 13", {bus.EX_rd, bus.EX_RegDst});
        end
        @(negedge Clk);
        ins = rtype(5'd0, 5'd0, 5'd10, F_ADD);
        wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        drive(ins, 32'h108, 1'b1, 1'b0);
        sb.push_back('{v:1'b1, rw:1'b1, mr:1'b0, op:ALU_ADD, rs:5'd0,
                       d1:32'h0, d2:32'h0, se:sx(ins), pc:32'h108});
        @(posedge Clk); #1;
        e = sb.pop_front(); a = obs();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL reg0_bypass got %h want %h", a, e);
        end
        @(negedge Clk);
        ins = rtype(5'd8, 5'd8, 5'd11, F_SUB);
        wb(1'b0, 5'd0, 32'h0);
        drive(ins, 32'h10c, 1'b1, 1'b0);
        sb.push_back('{v:1'b1, rw:1'b1, mr:1'b0, op:ALU_SUB, rs:5'd8,
                       d1:32'h1234_5678, d2:32'h1234_5678, se:sx(ins), pc:32'h10c});
        @(posedge Clk); #1;
        e = sb.pop_front(); a = obs();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL regfile_read got %h want %h", a, e);
        end
        @(negedge Clk);
        ins = rtype(5'd0, 5'd0, 5'd12, F_OR);
        drive(ins, 32'h110, 1'b1, 1'b0);
        sb.push_back('{v:1'b1, rw:1'b1, mr:1'b0, op:ALU_OR, rs:5'd0,
                       d1:32'h0, d2:32'h0, se:sx(ins), pc:32'h110});
        @(posedge Clk); #1;
        e = sb.pop_front(); a = obs();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL reg0_after_write got %h want %h", a, e);
        end
    endtask

    task automatic test_load_use();
        exp_t e, a;
        logic [31:0] ins;
        @(negedge Clk);
        ins = itype(OP_LW, 5'd2, 5'd4, 16'h0);
        drive(ins, 32'h200, 1'b1, 1'b0);
        #1;
        checks++;
        if (bus.Stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_no_stall_lw got %b want 0", bus.Stall);
        end
        sb.push_back('{v:1'b1, rw:1'b1, mr:1'b1, op:ALU_ADD, rs:5'd2,
                       d1:32'h0, d2:32'h0, se:32'h0, pc:32'h200});
        @(posedge Clk); #1;
        e = sb.pop_front(); a = obs();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL lu_lw got %h want %h", a, e);
        end
        @(negedge Clk);
        ins = rtype(5'd4, 5'd3, 5'd5, F_ADD);
        drive(ins, 32'h204, 1'b1, 1'b0);
        #1;
        checks++;
        if (bus.Stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall got %b want 1", bus.Stall);
        end
        sb.push_back('{v:1'b0, rw:1'b0, mr:1'b0, op:ALU_NOP, rs:5'd4,
                       d1:32'h0, d2:32'h0, se:sx(ins), pc:32'h204});
        @(posedge Clk); #1;
        e = sb.pop_front(); a = obs();
        checks++;
        if ({a.v, a.rw, a.mr, a.op} !== {e.v, e.rw, e.mr, e.op}) begin
            errors++;
            $display("FAIL lu_bubble got %h want %h",
                     {a.v, a.rw, a.mr, a.op}, {e.v, e.rw, e.mr, e.op});
        end
        @(negedge Clk);
        #1;
        checks++;
        if (bus.Stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall_len got %b want 0", bus.Stall);
        end
        sb.push_back('{v:1'b1, rw:1'b1, mr:1'b0, op:ALU_ADD, rs:5'd4,
                       d1:32'h0, d2:32'h0, se:sx(ins), pc:32'h204});
        @(posedge Clk); #1;
        e = sb.pop_front(); a = obs();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL lu_add got %h want %h", a, e);
        end
    endtask

    task automatic test_rt_dest();
        logic [31:0] ins;
        @(negedge Clk);
        drive(itype(OP_LW, 5'd2, 5'd4, 16'h0), 32'h300, 1'b1, 1'b0);
        @(posedge Clk); #1;
        @(negedge Clk);
        ins = itype(OP_ADDI, 5'd7, 5'd4, 16'h0001);
        drive(ins, 32'h304, 1'b1, 1'b0);
        #1;
        checks++;
        if (bus.Stall !== 1'b0) begin
            errors++;
            $display("FAIL addi_rt_dest got %b want 0", bus.Stall);
        end
        sb.push_back('{v:1'b1, rw:1'b1, mr:1'b0, op:ALU_ADD, rs:5'd7,
                       d1:32'h0, d2:32'h0, se:32'h1, pc:32'h304});
        @(posedge Clk); #1;
        begin
            exp_t e, a;
            e = sb.pop_front(); a = obs();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL addi got %h want %h", a, e);
            end
        end
        @(negedge Clk);
        drive(itype(OP_LW, 5'd2, 5'd4, 16'h0), 32'h308, 1'b1, 1'b0);
        @(posedge Clk); #1;
        @(negedge Clk);
        drive(itype(OP_SW, 5'd1, 5'd4, 16'h0), 32'h30c, 1'b1, 1'b0);
        #1;
        checks++;
        if (bus.Stall !== 1'b1) begin
            errors++;
            $display("FAIL sw_rt_src got %b want 1", bus.Stall);
        end
        @(posedge Clk); #1;
        @(negedge Clk);
        #1;
        checks++;
        if (bus.Stall !== 1'b0) begin
            errors++;
            $display("FAIL sw_stall_len got %b want 0", bus.Stall);
        end
        @(posedge Clk); #1;
        checks++;
        if ({bus.EX_Valid, bus.EX_MemWrite, bus.EX_ALUSrc, bus.EX_RegWrite} !== 4'b1110) begin
            errors++;
            $display("FAIL sw_ctrl got %b want 1110",
                     {bus.EX_Valid, bus.EX_MemWrite, bus.EX_ALUSrc, bus.EX_RegWrite});
        end
    endtask

    task automatic test_flush();
        exp_t e, a;
        logic [31:0] ins;
        @(negedge Clk);
        drive(itype(OP_LW, 5'd2, 5'd4, 16'h0), 32'h400, 1'b1, 1'b0);
        @(posedge Clk); #1;
        @(negedge Clk);
        ins = rtype(5'd4, 5'd3, 5'd5, F_ADD);
        drive(ins, 32'h404, 1'b1, 1'b1);
        #1;
        checks++;
        if (bus.Stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_stall got %b want 1", bus.Stall);
        end
        sb.push_back('{v:1'b0, rw:1'b0, mr:1'b0, op:ALU_NOP, rs:5'd4,
                       d1:32'h0, d2:32'h0, se:sx(ins), pc:32'h404});
        @(posedge Clk); #1;
        e = sb.pop_front(); a = obs();
        checks++;
        if ({a.v, a.rw, a.mr, a.op, bus.EX_MemtoReg, bus.EX_RegDst} !==
            {e.v, e.rw, e.mr, e.op, 2'b00}) begin
            errors++;
            $display("FAIL flush_kill got %h want %h", {a.v, a.rw, a.mr, a.op},
                     {e.v, e.rw, e.mr, e.op});
        end
        @(negedge Clk);
        drive(ins, 32'h408, 1'b1, 1'b0);
        #1;
        checks++;
        if (bus.Stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_extra got %b want 0", bus.Stall);
        end
        sb.push_back('{v:1'b1, rw:1'b1, mr:1'b0, op:ALU_ADD, rs:5'd4,
                       d1:32'h0, d2:32'h0, se:sx(ins), pc:32'h408});
        @(posedge Clk); #1;
        e = sb.pop_front(); a = obs();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL flush_next got %h want %h", a, e);
        end
    endtask

    task automatic test_sign_ext();
        logic [15:0] imms [2];
        logic [31:0] ins;
        imms[0] = 16'h8001;
        imms[1] = 16'h7FFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            ins = itype(OP_ADDI, 5'd0, 5'd1, imms[i]);
            drive(ins, 32'h500, 1'b1, 1'b0);
            bus64.Instruction    = ins;
            bus64.PCAddResult_in = 64'h500;
            bus64.IFID_Valid     = 1'b1;
            sb.push_back('{v:1'b1, rw:1'b1, mr:1'b0, op:ALU_ADD, rs:5'd0,
                           d1:32'h0, d2:32'h0,
                           se:(i == 0) ? 32'hFFFF_8001 : 32'h0000_7FFF,
                           pc:32'h500});
            sb64.push_back((i == 0) ? 64'hFFFF_FFFF_FFFF_8001 : 64'h0000_0000_0000_7FFF);
            @(posedge Clk); #1;
            begin
                exp_t e, a;
                logic [63:0] e64;
                e = sb.pop_front(); a = obs();
                e64 = sb64.pop_front();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL sext32_%0d got %h want %h", i, a, e);
                end
                checks++;
                if (bus64.EX_SignExtResult !== e64) begin
                    errors++;
                    $display("FAIL sext64_%0d got %h want %h", i,
                             bus64.EX_SignExtResult, e64);
                end
            end
        end
        bus64.IFID_Valid = 1'b0;
    endtask

    task automatic test_nop_cases();
        exp_t a;
        @(negedge Clk);
        drive({6'h3f, 26'h0ABCDEF}, 32'h600, 1'b1, 1'b0);
        @(posedge Clk); #1;
        a = obs();
        checks++;
        if ({a.v, a.rw, a.mr, a.op, bus.EX_MemWrite, bus.EX_Branch, bus.EX_ALUSrc} !==
            12'b1000_0000_0000) begin
            errors++;
            $display("FAIL unknown_op got %b want 100000000000",
                     {a.v, a.rw, a.mr, a.op, bus.EX_MemWrite, bus.EX_Branch, bus.EX_ALUSrc});
        end
        @(negedge Clk);
        drive(rtype(5'd1, 5'd2, 5'd3, F_ADD), 32'h604, 1'b0, 1'b0);
        @(posedge Clk); #1;
        a = obs();
        checks++;
        if ({a.v, a.rw, a.op} !== 8'h00) begin
            errors++;
            $display("FAIL ifid_invalid got %h want 00", {a.v, a.rw, a.op});
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, a;
        logic [31:0] ins;
        @(negedge Clk);
        ins = rtype(5'd5, 5'd0, 5'd6, F_ADD);
        wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        drive(ins, 32'h700, 1'b1, 1'b0);
        sb.push_back('{v:1'b1, rw:1'b1, mr:1'b0, op:ALU_ADD, rs:5'd5,
                       d1:32'hDEAD_BEEF, d2:32'h0, se:sx(ins), pc:32'h700});
        @(posedge Clk); #1;
        e = sb.pop_front(); a = obs();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL pre_reset got %h want %h", a, e);
        end
        wb(1'b0, 5'd0, 32'h0);
        #1;
        Reset = 1'b1;
        #1;
        a = obs();
        checks++;
        if (a !== '0) begin
            errors++;
            $display("FAIL async_reset got %h want 0", a);
        end
        @(negedge Clk);
        Reset = 1'b0;
        drive(ins, 32'h704, 1'b1, 1'b0);
        sb.push_back('{v:1'b1, rw:1'b1, mr:1'b0, op:ALU_ADD, rs:5'd5,
                       d1:32'h0, d2:32'h0, se:sx(ins), pc:32'h704});
        @(posedge Clk); #1;
        e = sb.pop_front(); a = obs();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL post_reset_r5 got %h want %h", a, e);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_rt_dest();
        test_flush();
        test_sign_ext();
        test_nop_cases();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
